// File: rtl/compare_tally_if.sv
// Handshake and statistics bundle for compare_tally.
// The master side supplies compare codes and control; the slave side reports statistics.
interface compare_tally_if #(
    parameter int unsigned CNT_W = 8
);
    logic             iValid;
    logic [2:0]       iData;
    logic             oReady;
    logic             iClear;
    logic             iFreeze;
    logic [CNT_W-1:0] oCnt_gt;
    logic [CNT_W-1:0] oCnt_lt;
    logic [CNT_W-1:0] oCnt_eq;
    logic [CNT_W-1:0] oRun;
    logic [CNT_W-1:0] oRun_max;
    logic [2:0]       oRun_code;
    logic             oErr;
    logic [1:0]       oState;

    modport master (
        output iValid, iData, iClear, iFreeze,
        input  oReady, oCnt_gt, oCnt_lt, oCnt_eq, oRun, oRun_max, oRun_code, oErr, oState
    );

    modport slave (
        input  iValid, iData, iClear, iFreeze,
        output oReady, oCnt_gt, oCnt_lt, oCnt_eq, oRun, oRun_max, oRun_code, oErr, oState
    );
endinterface

// File: rtl/compare_tally.sv
// Tallies one-hot comparator codes, tracks runs of identical codes and flags illegal codes.
// All statistics are registered; oReady is a pure decode of the FSM state.
module compare_tally #(
    parameter int unsigned CNT_W = 8
) (
    input logic            iClk,
    input logic            iRst_n,
    compare_tally_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StCount  = 2'b01,
        StFrozen = 2'b10
    } state_e;

    localparam logic [2:0]       CodeGt  = 3'b100;
    localparam logic [2:0]       CodeLt  = 3'b010;
    localparam logic [2:0]       CodeEq  = 3'b001;
    localparam logic [2:0]       CodeNone = 3'b000;
    localparam logic [CNT_W-1:0] CntMax  = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt_gt, w_cnt_gt_nxt;
    logic [CNT_W-1:0] r_cnt_lt, w_cnt_lt_nxt;
    logic [CNT_W-1:0] r_cnt_eq, w_cnt_eq_nxt;
    logic [CNT_W-1:0] r_run, w_run_nxt;
    logic [CNT_W-1:0] r_run_max, w_run_max_nxt;
    logic [2:0]       r_run_code, w_run_code_nxt;
    logic [2:0]       r_prev, w_prev_nxt;
    logic             r_err, w_err_nxt;
    logic             w_accept;
    logic             w_legal;
    logic             w_seen;

    assign w_legal = (bus.iData == CodeGt) || (bus.iData == CodeLt) || (bus.iData == CodeEq);
    assign w_accept = bus.iValid && (r_state != StFrozen) && !bus.iClear;
    // Counters saturate rather than wrap, so a non-zero count means a legal code was seen.
    assign w_seen = (r_cnt_gt != '0) || (r_cnt_lt != '0) || (r_cnt_eq != '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_gt_nxt   = r_cnt_gt;
        w_cnt_lt_nxt   = r_cnt_lt;
        w_cnt_eq_nxt   = r_cnt_eq;
        w_run_nxt      = r_run;
        w_run_max_nxt  = r_run_max;
        w_run_code_nxt = r_run_code;
        w_prev_nxt     = r_prev;
        w_err_nxt      = r_err;

        if (bus.iClear) begin
            w_state_nxt    = StIdle;
            w_cnt_gt_nxt   = '0;
            w_cnt_lt_nxt   = '0;
            w_cnt_eq_nxt   = '0;
            w_run_nxt      = '0;
            w_run_max_nxt  = '0;
            w_run_code_nxt = CodeNone;
            w_prev_nxt     = CodeNone;
            w_err_nxt      = 1'b0;
        end else begin
            if (w_accept && w_legal) begin
                unique case (bus.iData)
                    CodeGt:  w_cnt_gt_nxt = sat_inc(r_cnt_gt);
                    CodeLt:  w_cnt_lt_nxt = sat_inc(r_cnt_lt);
                    CodeEq:  w_cnt_eq_nxt = sat_inc(r_cnt_eq);
                    default: ;
                endcase
                w_run_nxt  = (bus.iData == r_prev) ? sat_inc(r_run) : CNT_W'(1);
                w_prev_nxt = bus.iData;
                // Strictly greater, so a tie keeps the earlier code.
                if (w_run_nxt > r_run_max) begin
                    w_run_max_nxt  = w_run_nxt;
                    w_run_code_nxt = bus.iData;
                end
            end else if (w_accept) begin
                w_err_nxt = 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (bus.iFreeze) begin
                        w_state_nxt = StFrozen;
                    end else if (w_accept && w_legal) begin
                        w_state_nxt = StCount;
                    end
                end
                StCount: begin
                    if (bus.iFreeze) begin
                        w_state_nxt = StFrozen;
                    end
                end
                StFrozen: begin
                    if (!bus.iFreeze) begin
                        w_state_nxt = w_seen ? StCount : StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state    <= StIdle;
            r_cnt_gt   <= '0;
            r_cnt_lt   <= '0;
            r_cnt_eq   <= '0;
            r_run      <= '0;
            r_run_max  <= '0;
            r_run_code <= CodeNone;
            r_prev     <= CodeNone;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt_gt   <= w_cnt_gt_nxt;
            r_cnt_lt   <= w_cnt_lt_nxt;
            r_cnt_eq   <= w_cnt_eq_nxt;
            r_run      <= w_run_nxt;
            r_run_max  <= w_run_max_nxt;
            r_run_code <= w_run_code_nxt;
            r_prev     <= w_prev_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.oReady    = (r_state != StFrozen);
    assign bus.oCnt_gt   = r_cnt_gt;
    assign bus.oCnt_lt   = r_cnt_lt;
    assign bus.oCnt_eq   = r_cnt_eq;
    assign bus.oRun      = r_run;
    assign bus.oRun_max  = r_run_max;
    assign bus.oRun_code = r_run_code;
    assign bus.oErr      = r_err;
    assign bus.oState    = r_state;
endmodule

// File: tb/tb_compare_tally.sv
// Bench for compare_tally: a behavioural statistics model checked every cycle,
// plus hand-computed pins for the headline scenarios.
module tb_compare_tally;
    localparam int CNT_W = 8;
    localparam int MAXV  = (1 << CNT_W) - 1;

    typedef struct {
        int         gt;
        int         lt;
        int         eq;
        int         run;
        int         rmax;
        logic [2:0] rcode;
        logic [2:0] prev;
        bit         err;
        int         st;
    } model_t;

    logic   clk;
    logic   rst_n;
    int     n_checks;
    int     n_pass;
    int     pin_id;
    model_t m;

    compare_tally_if #(.CNT_W(CNT_W)) bus ();

    compare_tally #(.CNT_W(CNT_W)) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t model_zero();
        model_t z;
        z.gt = 0; z.lt = 0; z.eq = 0; z.run = 0; z.rmax = 0;
        z.rcode = 3'b000; z.prev = 3'b000; z.err = 1'b0; z.st = 0;
        return z;
    endfunction

    function automatic int sat(input int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    function automatic model_t model_step(input model_t cur, input bit v, input logic [2:0] d,
                                          input bit c, input bit f);
        model_t n;
        bit     acc;
        bit     legal;
        n = cur;
        if (c) return model_zero();
        acc   = v && (cur.st != 2);
        legal = (d == 3'b100) || (d == 3'b010) || (d == 3'b001);
        if (acc && legal) begin
            if (d == 3'b100) n.gt = sat(n.gt + 1);
            if (d == 3'b010) n.lt = sat(n.lt + 1);
            if (d == 3'b001) n.eq = sat(n.eq + 1);
            n.run  = (d == cur.prev) ? sat(cur.run + 1) : 1;
            n.prev = d;
            if (n.run > n.rmax) begin
                n.rmax  = n.run;
                n.rcode = d;
            end
        end else if (acc) begin
            n.err = 1'b1;
        end
        if (f) n.st = 2;
        else if (cur.st == 2) n.st = (n.gt + n.lt + n.eq > 0) ? 1 : 0;
        else if (acc && legal) n.st = 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_zero();
        else m <= model_step(m, bus.iValid, bus.iData, bus.iClear, bus.iFreeze);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Single compare process: model every cycle, literal pins when requested.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        chk("cnt_gt", int'(bus.oCnt_gt), m.gt);
        chk("cnt_lt", int'(bus.oCnt_lt), m.lt);
        chk("cnt_eq", int'(bus.oCnt_eq), m.eq);
        chk("run", int'(bus.oRun), m.run);
        chk("run_max", int'(bus.oRun_max), m.rmax);
        chk("run_code", int'(bus.oRun_code), int'(m.rcode));
        chk("err", int'(bus.oErr), int'(m.err));
        chk("state", int'(bus.oState), m.st);
        chk("ready", int'(bus.oReady), (m.st != 2) ? 1 : 0);
        case (pin_id)
            1: begin
                chk("pin_seq_gt", int'(bus.oCnt_gt), 3);
                chk("pin_seq_lt", int'(bus.oCnt_lt), 1);
                chk("pin_seq_eq", int'(bus.oCnt_eq), 2);
                chk("pin_seq_run", int'(bus.oRun), 2);
                chk("pin_seq_max", int'(bus.oRun_max), 3);
                chk("pin_seq_code", int'(bus.oRun_code), 4);
                chk("pin_seq_state", int'(bus.oState), 1);
            end
            2: begin
                chk("pin_sat_eq", int'(bus.oCnt_eq), 255);
                chk("pin_sat_run", int'(bus.oRun), 255);
                chk("pin_sat_max", int'(bus.oRun_max), 255);
                chk("pin_sat_gt", int'(bus.oCnt_gt), 0);
                chk("pin_sat_lt", int'(bus.oCnt_lt), 0);
            end
            3: begin
                chk("pin_ill_err", int'(bus.oErr), 1);
                chk("pin_ill_lt", int'(bus.oCnt_lt), 2);
                chk("pin_ill_run", int'(bus.oRun), 2);
            end
            4: begin
                chk("pin_frz_ready", int'(bus.oReady), 0);
                chk("pin_frz_gt", int'(bus.oCnt_gt), 1);
                chk("pin_frz_state", int'(bus.oState), 2);
            end
            5: begin
                chk("pin_unfrz_state", int'(bus.oState), 1);
                chk("pin_unfrz_gt", int'(bus.oCnt_gt), 1);
            end
            6: begin
                chk("pin_clr_gt", int'(bus.oCnt_gt), 0);
                chk("pin_clr_lt", int'(bus.oCnt_lt), 0);
                chk("pin_clr_eq", int'(bus.oCnt_eq), 0);
                chk("pin_clr_err", int'(bus.oErr), 0);
                chk("pin_clr_state", int'(bus.oState), 0);
            end
            7, 9: begin
                chk("pin_rst_gt", int'(bus.oCnt_gt), 0);
                chk("pin_rst_lt", int'(bus.oCnt_lt), 0);
                chk("pin_rst_eq", int'(bus.oCnt_eq), 0);
                chk("pin_rst_run", int'(bus.oRun), 0);
                chk("pin_rst_max", int'(bus.oRun_max), 0);
                chk("pin_rst_code", int'(bus.oRun_code), 0);
                chk("pin_rst_err", int'(bus.oErr), 0);
                chk("pin_rst_state", int'(bus.oState), 0);
                chk("pin_rst_ready", int'(bus.oReady), 1);
            end
            8: begin
                chk("pin_rel_gt", int'(bus.oCnt_gt), 1);
                chk("pin_rel_run", int'(bus.oRun), 1);
                chk("pin_rel_lt", int'(bus.oCnt_lt), 0);
                chk("pin_rel_state", int'(bus.oState), 1);
            end
            default: ;
        endcase
    end

    task automatic step(input bit v, input logic [2:0] d, input bit c, input bit f);
        bus.iValid  = v;
        bus.iData   = d;
        bus.iClear  = c;
        bus.iFreeze = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iValid  = 1'b0;
        bus.iData   = 3'b000;
        bus.iClear  = 1'b0;
        bus.iFreeze = 1'b0;
    endtask

    task automatic pin(input int k);
        pin_id = k;
        @(negedge clk);
        #2;
        pin_id = 0;
    endtask

    logic [2:0] seq_a [6];
    logic [2:0] mix   [10];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pin_id   = 0;
        rst_n    = 1'b0;
        idle();
        seq_a = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001};
        mix   = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b000, 3'b010, 3'b111, 3'b001, 3'b001, 3'b001};
        repeat (2) @(posedge clk);
        #1;
        pin(9);
        rst_n = 1'b1;

        foreach (seq_a[i]) step(1'b1, seq_a[i], 1'b0, 1'b0);
        idle();
        pin(1);

        step(1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b011, 1'b0, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        idle();
        pin(3);

        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 3'b001, 1'b0, 1'b0);
        idle();
        pin(2);

        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b100, 1'b0, 1'b1);
        pin(4);
        step(1'b0, 3'b000, 1'b0, 1'b0);
        idle();
        pin(5);

        step(1'b1, 3'b100, 1'b1, 1'b0);
        idle();
        pin(6);

        // Illegal code in IDLE, tie handling, freeze with nothing counted, clear+freeze together.
        step(1'b1, 3'b011, 1'b0, 1'b0);
        foreach (mix[i]) step(1'b1, mix[i], 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b010, 1'b1, 1'b1);
        step(1'b1, 3'b010, 1'b0, 1'b1);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        idle();

        step(1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b1, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b100, 1'b0, 1'b0);
        bus.iValid = 1'b1;
        bus.iData  = 3'b100;
        #1;
        pin_id = 7;
        rst_n  = 1'b0;
        #2;
        pin_id = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(1'b1, 3'b100, 1'b0, 1'b0);
        idle();
        pin(8);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/compare_tally.md
COMPARE_TALLY -- requirements
Module: compare_tally

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of every counter and run-length output.
REQ-002 SHALL have port iClk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iValid  input  1  a compare code is present on iData.
REQ-005 SHALL have port iData  input  3  compare code from the upstream 8-bit comparator: 100 = a>b, 010 = a<b, 001 = a==b.
REQ-006 SHALL have port oReady  output  1  the block can accept a code this cycle.
REQ-007 SHALL have port iClear  input  1  synchronous clear of all statistics.
REQ-008 SHALL have port iFreeze  input  1  hold statistics and stop accepting codes.
REQ-009 SHALL have ports oCnt_gt, oCnt_lt, oCnt_eq  output  CNT_W each  the count of accepted 100, 010 and 001 codes respectively.
REQ-010 SHALL have port oRun  output  CNT_W  the length of the current run of identical legal codes.
REQ-011 SHALL have port oRun_max  output  CNT_W  the longest run seen since the last clear.
REQ-012 SHALL have port oRun_code  output  3  the code of the longest run; 000 if there has been none.
REQ-013 SHALL have port oErr  output  1  sticky flag, set once an illegal code has been accepted.
REQ-014 SHALL have port oState  output  2  FSM state: 00 IDLE, 01 COUNT, 10 FROZEN.

Function
REQ-015 SHALL accept a code on a rising edge when iValid=1, oReady=1 and iClear=0.
REQ-016 SHALL drive oReady combinationally from state: 1 in IDLE and COUNT, 0 in FROZEN.
REQ-017 SHALL make the effect of an accepted code visible on all outputs in the cycle after acceptance (latency 1, every output registered).
REQ-018 SHALL, on a legal accepted code, increment the matching counter, saturating at 2^CNT_W-1.
REQ-019 SHALL, on a legal code, set oRun = oRun+1 (saturating) if the code equals the previous legal code, else set oRun = 1.
REQ-020 SHALL update oRun_max and oRun_code only when the new oRun is strictly greater than oRun_max; ties keep the earlier code.
REQ-021 SHALL treat any code other than 100/010/001 as illegal: set oErr, change no counter and no run value, and leave the previous-code tracking unchanged.
REQ-022 SHALL move IDLE->COUNT on the first accepted legal code.
REQ-023 SHALL keep the state unchanged when an illegal code is accepted in IDLE.
REQ-024 SHALL move IDLE or COUNT -> FROZEN on the edge where iFreeze=1 and iClear=0.
REQ-025 SHALL still accept a code presented in the cycle iFreeze first rises, because oReady is 1 that cycle.
REQ-026 SHALL remain in FROZEN while iFreeze=1.
REQ-027 SHALL, when iFreeze=0 in FROZEN, return to COUNT if any legal code has been counted since clear, else to IDLE.
REQ-028 SHALL give iClear priority over acceptance and iFreeze: zero all counters, runs, oRun_code and oErr; enter IDLE; drop any code presented that cycle.
REQ-029 SHALL, when iClear=1 and iFreeze=1 together, clear first and enter IDLE; FROZEN is entered on the next edge if iFreeze is still 1 and iClear=0.
REQ-030 SHALL keep all outputs stable in FROZEN regardless of iValid/iData.

Reset
REQ-031 SHALL, while iRst_n=0, asynchronously force: state IDLE, all counters 0, oRun 0, oRun_max 0, oRun_code 000, oErr 0.
REQ-032 SHALL make oReady 1 during reset, as it follows state IDLE.
REQ-033 SHALL, on reset asserted mid-stream, abandon any in-flight code; the first code accepted after release is treated as the start of a new run.
REQ-034 SHALL accept codes from the first rising edge after iRst_n deasserts.

Verification
REQ-035 SHALL check: codes 100,100,100,010,001,001 on consecutive cycles -> oCnt_gt=3, oCnt_lt=1, oCnt_eq=2, oRun=2, oRun_max=3, oRun_code=100, oState=01.
REQ-036 SHALL check: 300 consecutive 001 codes with CNT_W=8 -> oCnt_eq=255, oRun=255, oRun_max=255; other counters 0.
REQ-037 SHALL check: 010, then 011, then 010 -> oErr=1, oCnt_lt=2, oRun=2.
REQ-038 SHALL check: iFreeze=1 with iValid=1 held for 3 cycles -> exactly one code accepted (first cycle), then oReady=0 and counters unchanged; on iFreeze=0 -> oState=01.
REQ-039 SHALL check: iClear=1 with iValid=1 and iData=100 in the same cycle -> next cycle all counters 0, oErr=0, oState=00.
REQ-040 SHALL check: iRst_n pulsed low mid-stream between clock edges -> outputs zero immediately, without waiting for an edge; after release, a 100 code gives oCnt_gt=1, oRun=1.
